// File: rtl/wptr_full_level.sv
// Write-side pointer, full/almost-full/overflow flags and occupancy for the async FIFO.
// The Gray read pointer from rclk is resynchronised here; everything else is wclk-local.
module wptr_full_level #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr_gray,
    input  logic [ADDRSIZE:0]   af_thresh,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
    logic [ADDRSIZE:0] wq_rptr;
    logic [ADDRSIZE:0] wq_rbin;

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic              wfull_q, wfull_d;
    logic              walmost_full_q, walmost_full_d;
    logic              wovf_q, wovf_d;
    logic              wr_accept;
    logic              wr_drop;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    always_comb begin
        wq_rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wq_rbin[i] = ^(wq_rptr >> i);
        end
    end

    assign wr_accept = winc & ~wfull_q;
    assign wr_drop   = winc &  wfull_q;

    always_comb begin
        wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, wr_accept};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        // Full when the next write pointer laps the synchronised read pointer.
        wfull_d        = (wptr_d == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]});
        wlevel_d       = wbin_d - wq_rbin;
        walmost_full_d = (wlevel_d >= af_thresh);
        wovf_d         = wovf_q;
        if (wovf_clr) begin
            wovf_d = 1'b0;
        end
        if (wr_drop) begin
            wovf_d = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wovf_q         <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wovf_q         <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign wovf         = wovf_q;

endmodule
